// File: rtl/binary_gcd_engine.sv
// Binary (Stein) GCD coprocessor: start/done handshake, shift/subtract datapath.
// Optional feature macro: GCD_ITER_CNT_EN adds the 8-bit saturating iters port
// reporting the number of CALC cycles used by the most recent operation.
// Outputs busy/done/gcd are registered from the current state, so they trail
// the state register by one cycle.
module binary_gcd_engine #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DONE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [7:0]       iters
`endif
);

  localparam int unsigned KW = $clog2(WIDTH + 1);
  localparam int unsigned HW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] x, x_next;
  logic [WIDTH-1:0] y, y_next;
  logic [KW-1:0]    k, k_next;
  logic [WIDTH-1:0] res, res_next;
  logic [HW-1:0]    hold, hold_next;
  logic [WIDTH:0]   diff_xy;
  logic [WIDTH-1:0] diff_yx;
  logic             calc_fin;

  // Single subtract pair: borrow of x-y doubles as the x>=y decision
  always_comb begin
    diff_xy = {1'b0, x} - {1'b0, y};
    diff_yx = y - x;
  end

  assign calc_fin = (state == CALC) && ((x == '0) || (y == '0));

  // Next-state and datapath step logic
  always_comb begin
    state_next = state;
    x_next     = x;
    y_next     = y;
    k_next     = k;
    res_next   = res;
    hold_next  = hold;
    case (state)
      IDLE: begin
        if (start) begin
          x_next     = a;
          y_next     = b;
          k_next     = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        if (x == '0) begin
          res_next   = y << k;
          hold_next  = '0;
          state_next = DONE;
        end else if (y == '0) begin
          res_next   = x << k;
          hold_next  = '0;
          state_next = DONE;
        end else if (!x[0] && !y[0]) begin
          x_next = x >> 1;
          y_next = y >> 1;
          k_next = k + KW'(1);
        end else if (!x[0]) begin
          x_next = x >> 1;
        end else if (!y[0]) begin
          y_next = y >> 1;
        end else if (!diff_xy[WIDTH]) begin
          x_next = diff_xy[WIDTH-1:0] >> 1;
        end else begin
          y_next = diff_yx >> 1;
        end
      end
      DONE: begin
        if (hold == HW'(DONE_CYCLES - 1)) begin
          state_next = IDLE;
        end else begin
          hold_next = hold + HW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      k     <= '0;
      res   <= '0;
      hold  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gcd   <= '0;
    end else begin
      state <= state_next;
      x     <= x_next;
      y     <= y_next;
      k     <= k_next;
      res   <= res_next;
      hold  <= hold_next;
      busy  <= (state != IDLE);
      done  <= (state == DONE);
      gcd   <= (state == DONE) ? res : '0;
    end
  end

`ifdef GCD_ITER_CNT_EN
  logic [7:0] cnt, cnt_next, cnt_inc, iters_next;

  // Saturating CALC-cycle counter; snapshot taken on the terminating step
  always_comb begin
    cnt_next   = cnt;
    iters_next = iters;
    cnt_inc    = (cnt == 8'hFF) ? cnt : (cnt + 8'd1);
    if (state == IDLE && start) begin
      cnt_next = '0;
    end else if (state == CALC) begin
      cnt_next = cnt_inc;
      if (calc_fin) begin
        iters_next = cnt_inc;
      end
    end
  end

  // Iteration counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      iters <= '0;
    end else begin
      cnt   <= cnt_next;
      iters <= iters_next;
    end
  end
`endif

endmodule
